// File: rtl/pulse_pkg.sv
// Shared constants and types for the NMR/ESR pulse sequencer.
// Holds width defaults, shadow register reset values and the FSM states.
package pulse_pkg;

  localparam int PER_W_DEF = 32;
  localparam int T_W_DEF   = 16;

  localparam int unsigned DEF_PER   = 100500;
  localparam int unsigned DEF_NUT_W = 0;
  localparam int unsigned DEF_NUT_D = 100;
  localparam int unsigned DEF_P1    = 30;
  localparam int unsigned DEF_DEL   = 200;
  localparam int unsigned DEF_P2    = 60;
  localparam int unsigned DEF_CP    = 1;
  localparam bit          DEF_BL    = 1'b1;
  localparam int unsigned DEF_P_BL  = 50;

  typedef enum logic [2:0] {
    IDLE,
    NUT,
    NGAP,
    P1,
    GAP,
    P2,
    TAIL
  } seq_state_t;

endpackage

// File: rtl/pulse_sequencer_if.sv
// Parameter/output bundle of the pulse sequencer.
// master: control-register side (drives en/upd/params, reads gates); slave: sequencer.
interface pulse_sequencer_if #(
  parameter int PER_W = pulse_pkg::PER_W_DEF,
  parameter int T_W   = pulse_pkg::T_W_DEF
);

  logic             en;
  logic             upd;
  logic [PER_W-1:0] per;
  logic [7:0]       nut_w;
  logic [T_W-1:0]   nut_d;
  logic [T_W-1:0]   p1wid;
  logic [T_W-1:0]   del;
  logic [T_W-1:0]   p2wid;
  logic [7:0]       cp;
  logic             bl;
  logic [7:0]       p_bl;

  logic             pulse;
  logic             sel2;
  logic             inh;
  logic             sync;
  logic             ovr;
  logic             active;

  modport master (
    output en, upd, per, nut_w, nut_d,
    output p1wid, del, p2wid, cp, bl, p_bl,
    input  pulse, sel2, inh, sync, ovr, active
  );

  modport slave (
    input  en, upd, per, nut_w, nut_d,
    input  p1wid, del, p2wid, cp, bl, p_bl,
    output pulse, sel2, inh, sync, ovr, active
  );

endinterface

// File: rtl/pulse_blanker.sv
// Receiver-inhibit generator: inh = pulse, or within p_bl cycles of a fall.
// Ports: clk, rst_n, pulse_d (next pulse), bl, p_bl -> inh (registered).
module pulse_blanker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pulse_d,
  input  logic       bl,
  input  logic [7:0] p_bl,
  output logic       inh
);

  // Remaining hold cycles; reloaded every high cycle so the
  // hold always counts from the latest falling edge.
  logic [7:0] hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      inh    <= 1'b0;
    end else begin
      if (pulse_d)
        hold_q <= p_bl;
      else if (hold_q != 8'd0)
        hold_q <= hold_q - 8'd1;
      inh <= bl && (pulse_d || (hold_q != 8'd0));
    end
  end

endmodule

// File: rtl/pulse_sequencer.sv
// Repetition-period pulse sequencer with double-buffered parameters.
// Ports: clk, rst_n, bus (slave: en/upd/params in; pulse/sel2/inh/sync/ovr/active out).
module pulse_sequencer
  import pulse_pkg::*;
#(
  parameter int               PER_W   = PER_W_DEF,
  parameter int               T_W     = T_W_DEF,
  // period loaded on reset; lowered only for fast bring-up
  parameter logic [PER_W-1:0] RST_PER = PER_W'(DEF_PER)
) (
  input  logic             clk,
  input  logic             rst_n,
  pulse_sequencer_if.slave bus
);

  localparam int CW = (PER_W > 32) ? PER_W : 32;

  typedef struct packed {
    logic [PER_W-1:0] per;
    logic [7:0]       nut_w;
    logic [T_W-1:0]   nut_d;
    logic [T_W-1:0]   p1;
    logic [T_W-1:0]   del;
    logic [T_W-1:0]   p2;
    logic [7:0]       cp;
    logic             bl;
    logic [7:0]       p_bl;
  } shadow_t;

  typedef struct packed {
    seq_state_t     st;
    logic [T_W-1:0] cnt;
    logic [7:0]     rem;
  } seg_t;

  localparam shadow_t SH_RST = '{
    per:   RST_PER,
    nut_w: 8'(DEF_NUT_W),
    nut_d: T_W'(DEF_NUT_D),
    p1:    T_W'(DEF_P1),
    del:   T_W'(DEF_DEL),
    p2:    T_W'(DEF_P2),
    cp:    8'(DEF_CP),
    bl:    DEF_BL,
    p_bl:  8'(DEF_P_BL)
  };

  function automatic logic [T_W-1:0] seg_len(
    seq_state_t s,
    shadow_t    sh
  );
    logic [T_W-1:0] l;
    l = '0;
    case (s)
      NUT:       l = T_W'(sh.nut_w);
      NGAP:      l = (sh.nut_w != 8'd0) ? sh.nut_d : '0;
      P1:        l = sh.p1;
      GAP, TAIL: l = sh.del;
      P2:        l = sh.p2;
      default:   l = '0;
    endcase
    return l;
  endfunction

  // Segment order: NUT NGAP P1 {GAP P2 TAIL}* IDLE.
  // TAIL+GAP together form the 2*del spacing between P2 pulses.
  function automatic seg_t succ(seg_t c, shadow_t sh);
    seg_t n;
    n     = c;
    n.cnt = '0;
    case (c.st)
      NUT:  n.st = NGAP;
      NGAP: n.st = P1;
      P1: begin
        // all-empty echo train would never reach a non-empty segment
        if (sh.cp == 8'd0 || (sh.del == '0 && sh.p2 == '0)) begin
          n.st = IDLE;
        end else begin
          n.st  = GAP;
          n.rem = sh.cp;
        end
      end
      GAP:  n.st = P2;
      P2: begin
        if (c.rem <= 8'd1) begin
          n.st = IDLE;
        end else begin
          n.st  = TAIL;
          n.rem = c.rem - 8'd1;
        end
      end
      TAIL:    n.st = GAP;
      default: n.st = IDLE;
    endcase
    return n;
  endfunction

  // Skip empty segments combinationally; at most six hops are needed.
  function automatic seg_t seek(seg_t c0, shadow_t sh);
    seg_t           c;
    logic           done;
    logic [T_W-1:0] l;
    c    = c0;
    done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!done) begin
        l = seg_len(c.st, sh);
        if (c.st == IDLE || l != '0) begin
          c.cnt = l;
          done  = 1'b1;
        end else begin
          c = succ(c, sh);
        end
      end
    end
    if (!done) begin
      c.st  = IDLE;
      c.cnt = '0;
    end
    return c;
  endfunction

  shadow_t          sh_q;
  shadow_t          sh_d;
  shadow_t          sh_in;
  logic             pend_q;
  logic             pend_d;
  logic             run_q;
  logic [PER_W-1:0] t_q;
  logic [PER_W-1:0] t_d;
  logic [PER_W-1:0] p_cur;
  logic             wrap;
  logic             commit;
  logic             start;

  seq_state_t       st_q;
  logic [T_W-1:0]   cnt_q;
  logic [7:0]       rem_q;
  seg_t             cur;
  seg_t             nxt;

  logic [31:0]      e_s1;
  logic [31:0]      e_p1;
  logic [31:0]      e_rep;
  logic [31:0]      e_end;

  logic             pulse_d;
  logic             sel2_d;
  logic             sync_d;
  logic             ovr_d;
  logic             active_d;
  logic             pulse_q;
  logic             sel2_q;
  logic             sync_q;
  logic             ovr_q;
  logic             active_q;
  logic             inh_q;

  always_comb begin
    sh_in.per   = bus.per;
    sh_in.nut_w = bus.nut_w;
    sh_in.nut_d = bus.nut_d;
    sh_in.p1    = bus.p1wid;
    sh_in.del   = bus.del;
    sh_in.p2    = bus.p2wid;
    sh_in.cp    = bus.cp;
    sh_in.bl    = bus.bl;
    sh_in.p_bl  = bus.p_bl;

    p_cur  = (sh_q.per < PER_W'(2)) ? PER_W'(2) : sh_q.per;
    wrap   = run_q && (t_q == p_cur - PER_W'(1));
    commit = bus.en && wrap && pend_q;
    sh_d   = commit ? sh_in : sh_q;

    pend_d = pend_q;
    if (bus.en)
      pend_d = commit ? 1'b0 : (pend_q | bus.upd);
  end

  // End of the last window, used only for overrun detection.
  always_comb begin
    e_s1  = (sh_q.nut_w != 8'd0) ?
            32'(sh_q.nut_w) + 32'(sh_q.nut_d) : 32'd0;
    e_p1  = e_s1 + 32'(sh_q.p1);
    e_rep = 32'(sh_q.del) * 32'd2 + 32'(sh_q.p2);
    e_end = e_p1;
    if (sh_q.cp != 8'd0)
      e_end = e_p1 + 32'(sh_q.del)
            + 32'(sh_q.cp - 8'd1) * e_rep
            + 32'(sh_q.p2);
  end

  always_comb begin
    cur.st  = st_q;
    cur.cnt = cnt_q;
    cur.rem = rem_q;
    nxt     = cur;
    t_d     = t_q;
    start   = !run_q || wrap;

    if (!bus.en) begin
      nxt.st  = IDLE;
      nxt.cnt = '0;
      nxt.rem = '0;
      t_d     = '0;
    end else if (start) begin
      // wrap beats any segment end in the same cycle
      t_d     = '0;
      nxt.st  = NUT;
      nxt.cnt = '0;
      nxt.rem = '0;
      nxt     = seek(nxt, sh_d);
    end else begin
      t_d = t_q + PER_W'(1);
      if (st_q == IDLE)
        nxt = cur;
      else if (cnt_q > T_W'(1))
        nxt.cnt = cnt_q - T_W'(1);
      else
        nxt = seek(succ(cur, sh_q), sh_q);
    end
  end

  always_comb begin
    pulse_d  = 1'b0;
    sel2_d   = 1'b0;
    active_d = (nxt.st != IDLE);
    sync_d   = bus.en && (t_d == '0);
    ovr_d    = bus.en && !start &&
               (t_d == p_cur - PER_W'(1)) &&
               (CW'(e_end) > CW'(p_cur));
    unique case (1'b1)
      (nxt.st == P2): begin
        pulse_d = 1'b1;
        sel2_d  = 1'b1;
      end
      (nxt.st == NUT),
      (nxt.st == P1): pulse_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
    end else begin
      st_q  <= nxt.st;
      cnt_q <= nxt.cnt;
      rem_q <= nxt.rem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q     <= SH_RST;
      pend_q   <= 1'b0;
      run_q    <= 1'b0;
      t_q      <= '0;
      pulse_q  <= 1'b0;
      sel2_q   <= 1'b0;
      sync_q   <= 1'b0;
      ovr_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      pend_q   <= pend_d;
      run_q    <= bus.en;
      t_q      <= t_d;
      pulse_q  <= pulse_d;
      sel2_q   <= sel2_d;
      sync_q   <= sync_d;
      ovr_q    <= ovr_d;
      active_q <= active_d;
    end
  end

  pulse_blanker u_blank (
    .clk     (clk),
    .rst_n   (rst_n),
    .pulse_d (pulse_d),
    .bl      (bus.en && sh_d.bl),
    .p_bl    (sh_d.p_bl),
    .inh     (inh_q)
  );

  assign bus.pulse  = pulse_q;
  assign bus.sel2   = sel2_q;
  assign bus.inh    = inh_q;
  assign bus.sync   = sync_q;
  assign bus.ovr    = ovr_q;
  assign bus.active = active_q;

endmodule
